// File: rtl/vga_text_pkg.sv
// Shared geometry, clear fill code, arbiter state and write-entry types for the text RAM path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_text_pkg;

    localparam int H_DISP     = 640;
    localparam int V_DISP     = 480;
    localparam int CW_LOG2    = 3;
    localparam int CH_LOG2    = 4;
    localparam int COLS       = H_DISP >> CW_LOG2;
    localparam int ROWS       = V_DISP >> CH_LOG2;
    localparam int TEXT_CELLS = COLS * ROWS;
    localparam int TEXT_AW    = 12;

    localparam logic [7:0] CLR_CHAR = 8'h20;

    typedef enum logic {
        IDLE,
        CLEAR
    } arb_state_t;

    typedef struct packed {
        logic [TEXT_AW-1:0] addr;
        logic [7:0]         data;
    } wr_ent_t;

    // row*80 + col with shifts and adds; only meaningful inside the active area.
    function automatic logic [TEXT_AW-1:0] cell_addr(input logic [9:0] xpos, input logic [9:0] ypos);
        logic [TEXT_AW-1:0] row;
        logic [TEXT_AW-1:0] col;
        row = TEXT_AW'(ypos >> CH_LOG2);
        col = TEXT_AW'(xpos >> CW_LOG2);
        return (row << 6) + (row << 4) + col;
    endfunction

endpackage

// File: rtl/vga_text_ram_arb_fifo.sv
// Synchronous FIFO holding pending host writes {addr,data}.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: full blocks pushes; pop on empty is ignored; push+pop together keep the count.
module text_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge vga_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/vga_text_ram_arb.sv
// Text RAM arbiter: display fetch > screen clear > queued host writes on one single-port RAM.
// Latency: char_code/char_valid two cycles after the read slot; host writes land on a later free cycle.
// Backpressure: wr_ready drops while the write FIFO is full; clear holds the FIFO until it finishes.
module vga_text_ram_arb
    import vga_text_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pixel_xpos,
    input  logic [9:0]  pixel_ypos,
    input  logic        wr_req,
    input  logic [11:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        addr_err,
    output logic [11:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  char_code,
    output logic        char_valid
);

    arb_state_t         state;
    logic [TEXT_AW-1:0] clr_cnt;
    logic               rd_p1;
    logic               rdy_en;
    logic               slot;
    logic [TEXT_AW-1:0] rd_addr;
    logic               free;
    logic               clr_wr;
    logic               accept;
    logic               addr_ok;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    wr_ent_t            push_ent;
    wr_ent_t            head;

    assign slot = (pixel_xpos < 10'(H_DISP)) && (pixel_ypos < 10'(V_DISP)) &&
                  (pixel_xpos[CW_LOG2-1:0] == '0);
    assign rd_addr = cell_addr(pixel_xpos, pixel_ypos);

    // Out-of-range writes are handshaken but never enter the FIFO.
    assign addr_ok  = (wr_addr < 12'(TEXT_CELLS));
    assign wr_ready = rdy_en && !fifo_full;
    assign accept   = wr_req && wr_ready;
    assign push     = accept && addr_ok;
    assign push_ent = '{addr: wr_addr, data: wr_data};

    assign free     = sys_rst_n && !slot;
    assign clr_wr   = free && (state == CLEAR);
    assign pop      = free && (state == IDLE) && !clr_req && !fifo_empty;
    assign clr_busy = (state == CLEAR);

    text_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wr_ent_t))
    ) u_fifo (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .push      (push),
        .push_dat  (push_ent),
        .pop       (pop),
        .pop_dat   (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (sys_rst_n && slot) begin
            ram_addr = rd_addr;
        end else if (clr_wr) begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt;
            ram_wdata = CLR_CHAR;
        end else if (pop) begin
            ram_we    = 1'b1;
            ram_addr  = head.addr;
            ram_wdata = head.data;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            rd_p1      <= 1'b0;
            rdy_en     <= 1'b0;
            char_code  <= '0;
            char_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            rdy_en     <= 1'b1;
            rd_p1      <= slot;
            char_valid <= rd_p1;
            addr_err   <= accept && !addr_ok;
            if (rd_p1) begin
                char_code <= ram_rdata;
            end
            unique case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_wr) begin
                        if (clr_cnt == 12'(TEXT_CELLS - 1)) begin
                            state <= IDLE;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_ram_arb.sv
// Randomized scoreboard bench for vga_text_ram_arb with a behavioural RAM and a cell-array model.
// Latency: n/a. Backpressure: host writes are held until wr_ready.
module tb_vga_text_ram_arb;
    import vga_text_pkg::*;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [9:0]  pixel_xpos = '0;
    logic [9:0]  pixel_ypos = '0;
    logic        wr_req = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        clr_req = 1'b0;
    logic        wr_ready, clr_busy, addr_err, ram_we, char_valid;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata, char_code;
    logic [7:0]  ram_rdata = '0;

    vga_text_ram_arb #(.FIFO_DEPTH(4)) dut (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .addr_err   (addr_err),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .char_code  (char_code),
        .char_valid (char_valid)
    );

    always #20 vga_clk = ~vga_clk;

    logic [7:0] ram [4096];
    always @(posedge vga_clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    typedef struct { int due; logic [7:0] val; } rd_t;
    typedef struct { int addr; logic [7:0] data; } wr_t;

    logic [7:0] model_mem [TEXT_CELLS];
    rd_t  rd_q[$];
    wr_t  host_q[$];
    int   err_q[$];
    bit   clr_active = 0;
    int   clr_idx = 0;
    bit   busy_model = 0;
    bit   exp_slot = 0;
    int   exp_slot_addr = 0;
    bit   last_acc = 0;
    bit   saw_full = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge vga_clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_slot(input int x, input int y);
        return (x < 640) && (y < 480) && (x % 8 == 0);
    endfunction

    function automatic int cell_of(input int x, input int y);
        return (y / 16) * 80 + x / 8;
    endfunction

    // Drive one cycle's inputs and record what the DUT owes us for them.
    task automatic step_begin(input int x, input int y);
        pixel_xpos = 10'(x);
        pixel_ypos = 10'(y);
        exp_slot = sys_rst_n && is_slot(x, y);
        last_acc = 0;
        if (exp_slot) begin
            exp_slot_addr = cell_of(x, y);
            rd_q.push_back('{due: cyc + 2, val: model_mem[exp_slot_addr]});
        end
        if (sys_rst_n) begin
            if (clr_active) chk("wr_ready_occupancy", int'(wr_ready), int'(host_q.size() < 4));
            if (clr_active && !wr_ready) saw_full = 1;
            if (wr_req && wr_ready) begin
                last_acc = 1;
                if (int'(wr_addr) < TEXT_CELLS) host_q.push_back('{addr: int'(wr_addr), data: wr_data});
                else err_q.push_back(cyc + 1);
            end
            if (clr_req && !clr_active) begin
                clr_active = 1;
                clr_idx = 0;
            end
        end
    endtask

    task automatic step_end();
        @(posedge vga_clk);
        #1;
        clr_req = 1'b0;
        if (last_acc) wr_req = 1'b0;
    endtask

    task automatic step(input int x, input int y);
        step_begin(x, y);
        step_end();
    endtask

    task automatic rand_step();
        int x, y;
        case ($urandom_range(0, 3))
            0: begin x = $urandom_range(0, 79) * 8; y = $urandom_range(0, 479); end
            1: begin x = $urandom_range(0, 639);    y = $urandom_range(0, 479); end
            2: begin x = $urandom_range(640, 799);  y = $urandom_range(0, 524); end
            default: begin x = $urandom_range(0, 799); y = $urandom_range(480, 524); end
        endcase
        step(x, y);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((host_q.size() != 0 || clr_active || wr_req) && n < 8000) begin
            step(700, 500);
            n++;
        end
        chk(name, int'(n < 8000), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, int'(wr_ready), 0);
        chk({tag, "_clr_busy"}, int'(clr_busy), 0);
        chk({tag, "_ram_we"}, int'(ram_we), 0);
        chk({tag, "_ram_addr"}, int'(ram_addr), 0);
        chk({tag, "_char_code"}, int'(char_code), 0);
        chk({tag, "_char_valid"}, int'(char_valid), 0);
        chk({tag, "_addr_err"}, int'(addr_err), 0);
    endtask

    task automatic assert_reset();
        sys_rst_n = 1'b0;
        wr_req = 1'b0;
        clr_req = 1'b0;
        host_q.delete();
        rd_q.delete();
        err_q.delete();
        clr_active = 0;
    endtask

    // Scoreboard: compares RAM port, display output, addr_err and clr_busy every cycle.
    always @(negedge vga_clk) begin
        if (!sys_rst_n) begin
            busy_model = 0;
        end else begin
            if (exp_slot) begin
                chk("slot_ram_we", int'(ram_we), 0);
                chk("slot_ram_addr", int'(ram_addr), exp_slot_addr);
            end else if (ram_we) begin
                if (clr_active) begin
                    chk("clear_addr", int'(ram_addr), clr_idx);
                    chk("clear_data", int'(ram_wdata), int'(CLR_CHAR));
                    model_mem[clr_idx] = CLR_CHAR;
                    clr_idx++;
                    if (clr_idx == TEXT_CELLS) clr_active = 0;
                end else if (host_q.size() != 0) begin
                    wr_t w;
                    w = host_q.pop_front();
                    chk("host_wr_addr", int'(ram_addr), w.addr);
                    chk("host_wr_data", int'(ram_wdata), int'(w.data));
                    model_mem[w.addr] = w.data;
                end else begin
                    chk("unexpected_ram_we_addr", int'(ram_addr), -1);
                end
            end else begin
                chk("idle_ram_addr", int'(ram_addr), 0);
            end

            if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
                rd_t r;
                r = rd_q.pop_front();
                chk("char_valid", int'(char_valid), 1);
                chk("char_code", int'(char_code), int'(r.val));
            end else begin
                chk("char_valid_quiet", int'(char_valid), 0);
            end

            if (err_q.size() != 0 && err_q[0] == cyc) begin
                void'(err_q.pop_front());
                chk("addr_err_pulse", int'(addr_err), 1);
            end else begin
                chk("addr_err_quiet", int'(addr_err), 0);
            end

            chk("clr_busy", int'(clr_busy), int'(busy_model));
            busy_model = clr_active;
        end
    end

    initial begin
        #2400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        int burst_left;
        int k;
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h41;
        for (int i = 0; i < TEXT_CELLS; i++) model_mem[i] = ram[i];

        // Reset, then release with the beam parked on cell 0.
        #1;
        step(0, 0);
        step(0, 0);
        @(negedge vga_clk);
        chk_reset_outputs("reset");
        @(posedge vga_clk);
        #1;
        sys_rst_n = 1'b1;
        chk("wr_ready_release_cycle", int'(wr_ready), 0);
        step(0, 0);
        chk("wr_ready_after_release", int'(wr_ready), 1);
        step(1, 0);
        step(2, 0);

        // Last cell of the screen, then just past the active area.
        step(632, 479);
        step(640, 479);
        step(641, 479);
        step(700, 479);

        // Random traffic: mixed beam positions and host writes, some out of range.
        for (int i = 0; i < 3000; i++) begin
            if (!wr_req && $urandom_range(0, 2) == 0) begin
                wr_req = 1'b1;
                wr_addr = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(2400, 4095))
                                                      : 12'($urandom_range(0, 2399));
                wr_data = 8'($urandom);
            end
            rand_step();
        end
        wait_idle("drain_random");

        // Write to cell 5 parked in the FIFO across a read slot.
        wr_req = 1'b1; wr_addr = 12'd5; wr_data = 8'h58;
        step(7, 0);
        step_begin(8, 0);
        @(negedge vga_clk);
        chk("defer_slot_we", int'(ram_we), 0);
        chk("defer_slot_addr", int'(ram_addr), 1);
        step_end();
        step_begin(9, 0);
        @(negedge vga_clk);
        chk("defer_write_we", int'(ram_we), 1);
        chk("defer_write_addr", int'(ram_addr), 5);
        chk("defer_write_data", int'(ram_wdata), 8'h58);
        step_end();
        step(40, 0);
        step(41, 0);
        step(42, 0);

        // Clear with a same-cycle write, a retrigger mid-clear and a 6-write burst.
        clr_req = 1'b1;
        wr_req = 1'b1; wr_addr = 12'd10; wr_data = 8'h31;
        step(700, 0);
        burst_left = 6;
        k = 0;
        saw_full = 0;
        while ((clr_active || host_q.size() != 0 || burst_left != 0 || wr_req) && k < 8000) begin
            if (k == 100) clr_req = 1'b1;
            if (k >= 200 && !wr_req && burst_left != 0) begin
                wr_req = 1'b1;
                wr_addr = 12'(106 - burst_left);
                wr_data = 8'(8'h66 - burst_left);
                burst_left--;
            end
            rand_step();
            k++;
        end
        chk("clear_complete", int'(k < 8000), 1);
        chk("fifo_full_seen", int'(saw_full), 1);

        // Read the whole screen back through the display path.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                step(c * 8, r * 16);
        step(700, 0);
        step(700, 0);
        mism = 0;
        for (int i = 0; i < TEXT_CELLS; i++) if (ram[i] !== model_mem[i]) mism++;
        chk("ram_image_mismatches", mism, 0);

        // Out-of-range writes are accepted and dropped.
        wr_req = 1'b1; wr_addr = 12'd2400; wr_data = 8'hff;
        step(700, 0);
        wr_req = 1'b1; wr_addr = 12'd4095; wr_data = 8'hee;
        step(700, 0);
        for (int i = 0; i < 5; i++) step(700, 0);

        // Reset in the middle of a clear with writes queued behind it.
        clr_req = 1'b1;
        step(700, 0);
        for (int i = 0; i < 40; i++) begin
            if (i == 5 || i == 6) begin
                wr_req = 1'b1; wr_addr = 12'(200 + i); wr_data = 8'h77;
            end
            step(700, 0);
        end
        assert_reset();
        step(700, 0);
        @(negedge vga_clk);
        chk_reset_outputs("midclear_reset");
        @(posedge vga_clk);
        #1;
        sys_rst_n = 1'b1;
        step(700, 0);
        chk("wr_ready_after_rerelease", int'(wr_ready), 1);
        for (int i = 0; i < 50; i++) step(700, 0);
        for (int i = 0; i < 20; i++) rand_step();
        step(700, 0);
        step(700, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
